// File: rtl/sync_filt.sv
// sync_filt: multi-channel input synchronizer with debounce filter.
//
// Each channel passes an asynchronous level through an NFF-deep flip-flop
// chain. A stability counter then debounces it. The filtered level y[i]
// takes the synchronized value s_i only after s_i has differed from y[i]
// for FLEN consecutive cycles. Any return to y[i] before then restarts the
// count. Registered rise/fall strobes mark each change of y[i].
//
// Optional feature macro: SYNC_FILT_STRETCH_EN
//   defined   : each strobe is ORed with a one-cycle-delayed copy, so it is
//               2 cycles wide (visible to a clk/2 enabled consumer).
//   undefined : strobes are exactly 1 cycle wide; no delay flops exist.
//
// Parameters:
//   P_NCH      number of channels (>= 1)
//   P_NFF      synchronizer depth (clamped to >= 2)
//   P_FILT_LEN stable cycles required before y changes (clamped to >= 1)
//   P_DEFVAL   per-channel reset value of the sync stages and of y
//
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   a     asynchronous inputs, one bit per channel
//   y     synchronized, debounced levels
//   rise  strobe when y[i] goes 0->1
//   fall  strobe when y[i] goes 1->0
module sync_filt #(
    parameter int               P_NCH      = 4,
    parameter int               P_NFF      = 2,
    parameter int               P_FILT_LEN = 4,
    parameter logic [P_NCH-1:0] P_DEFVAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P_NCH-1:0] a,
    output logic [P_NCH-1:0] y,
    output logic [P_NCH-1:0] rise,
    output logic [P_NCH-1:0] fall
);

    localparam int NFF  = (P_NFF < 2) ? 2 : P_NFF;
    localparam int FLEN = (P_FILT_LEN < 1) ? 1 : P_FILT_LEN;
    localparam int CW   = $clog2(FLEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FLEN - 1);

    for (genvar i = 0; i < P_NCH; i++) begin : g_ch

        // ---- stage p0: synchronizer chain, no logic between stages ----
        (* ASYNC_REG = "TRUE" *) logic [NFF-1:0] ff_p0;
        logic s_p0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ff_p0 <= {NFF{P_DEFVAL[i]}};
            end else begin
                ff_p0 <= {ff_p0[NFF-2:0], a[i]};
            end
        end

        assign s_p0 = ff_p0[NFF-1];

        // ---- stage p1: stability counter, filtered level, strobes ----
        logic [CW-1:0] cnt_p1;
        logic          y_p1;
        logic          rise_p1;
        logic          fall_p1;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_p1  <= '0;
                y_p1    <= P_DEFVAL[i];
                rise_p1 <= 1'b0;
                fall_p1 <= 1'b0;
            end else begin
                rise_p1 <= 1'b0;
                fall_p1 <= 1'b0;
                if (s_p0 == y_p1) begin
                    cnt_p1 <= '0;
                end else if (cnt_p1 == CNT_LAST) begin
                    // s has differed for FLEN cycles: accept it. The strobe
                    // is registered alongside y so both appear together.
                    y_p1    <= s_p0;
                    cnt_p1  <= '0;
                    rise_p1 <= s_p0;
                    fall_p1 <= ~s_p0;
                end else begin
                    cnt_p1 <= cnt_p1 + CW'(1);
                end
            end
        end

        assign y[i] = y_p1;

`ifdef SYNC_FILT_STRETCH_EN
        // ---- stage p2: one-cycle delayed strobe copies for stretching ----
        logic rise_p2;
        logic fall_p2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rise_p2 <= 1'b0;
                fall_p2 <= 1'b0;
            end else begin
                rise_p2 <= rise_p1;
                fall_p2 <= fall_p1;
            end
        end

        assign rise[i] = rise_p1 | rise_p2;
        assign fall[i] = fall_p1 | fall_p2;
`else
        assign rise[i] = rise_p1;
        assign fall[i] = fall_p1;
`endif

    end

endmodule
